// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer.
// Owns the PC and drives a synchronous-read instruction memory through a
// two-step pipeline: F1 presents pc_q on imem_addr_o, F2 holds the address
// whose data arrives on imem_rdata_i, then the IF/ID output register.
// Handles ID stalls (address replay), EX redirects (squash) and halt at END_ADDR.
// Optional feature: define IF_FETCH_PERF_CNT_EN to add saturating fetch/stall
// counters (fetch_cnt_o, stall_cnt_o).
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] END_ADDR  = 32'd36,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instn_o,
  output logic [31:0] instn_pc_o,
  output logic [31:0] nextpc_o,
  output logic        instn_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic        range_err_o
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  // First byte address beyond the instruction memory.
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc_q;      // next address to issue (F1)
  logic [31:0] f2_pc;     // address whose data is on imem_rdata_i this cycle
  logic        f2_valid;  // F2 holds a live (non-squashed) fetch
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // While stalled with a live F2 entry, re-present its address so the same
  // word comes back on the next cycle; the memory has no hold of its own.
  assign imem_addr_o = (stall_i && f2_valid) ? f2_pc : pc_q;

  // Fetch FSM plus the registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_BOOT;
      pc_q          <= RESET_PC;
      f2_pc         <= 32'd0;
      f2_valid      <= 1'b0;
      instn_o       <= 32'd0;
      instn_pc_o    <= 32'd0;
      nextpc_o      <= RESET_PC + 32'd4;
      instn_valid_o <= 1'b0;
      halted_o      <= 1'b0;
      misalign_o    <= 1'b0;
      range_err_o   <= 1'b0;
    end else begin
      // Pulse by default; only a misaligned redirect raises it again.
      misalign_o <= 1'b0;
      case (state)
        S_BOOT: begin
          // Memory already saw pc_q this cycle, so F2 owns it next.
          f2_pc    <= pc_q;
          f2_valid <= 1'b1;
          pc_q     <= pc_inc;
          state    <= S_RUN;
        end

        S_RUN: begin
          if (branch_taken_i) begin
            // Redirect wins over stall; the in-flight F2 word is dropped.
            pc_q          <= branch_target_i & ~32'd3;
            misalign_o    <= |branch_target_i[1:0];
            f2_valid      <= 1'b0;
            instn_valid_o <= 1'b0;
          end else if (!stall_i) begin
            instn_o       <= imem_rdata_i;
            instn_pc_o    <= f2_pc;
            nextpc_o      <= f2_pc + 32'd4;
            instn_valid_o <= f2_valid;
            if (pc_q == END_ADDR) begin
              // END_ADDR itself is never fetched.
              f2_valid <= 1'b0;
              state    <= S_HALT;
            end else begin
              f2_pc    <= pc_q;
              f2_valid <= 1'b1;
              pc_q     <= pc_inc;
              if (pc_q >= MEM_LIMIT) range_err_o <= 1'b1;
            end
          end
        end

        S_HALT: begin
          // Drain the last instruction once ID accepts it; only reset leaves.
          if (!stall_i) begin
            instn_valid_o <= 1'b0;
            halted_o      <= 1'b1;
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic run_fetch;
  logic run_stall;

  assign run_fetch = (state == S_RUN) && !branch_taken_i && !stall_i && f2_valid;
  assign run_stall = (state == S_RUN) && !branch_taken_i && stall_i;

  // Saturating event counters for delivered fetches and ID stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (run_fetch && (fetch_cnt_o != 32'hFFFF_FFFF)) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (run_stall && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scoreboard bench for if_fetch_ctrl.
// Stimulus pushes the expected instruction PCs; a negedge monitor pops and
// compares each newly delivered instruction and checks holds during stalls.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instn_o;
  logic [31:0] instn_pc_o;
  logic [31:0] nextpc_o;
  logic        instn_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic        range_err_o;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  if_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .instn_o        (instn_o),
    .instn_pc_o     (instn_pc_o),
    .nextpc_o       (nextpc_o),
    .instn_valid_o  (instn_valid_o),
    .halted_o       (halted_o),
    .misalign_o     (misalign_o),
    .range_err_o    (range_err_o)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory, word k holds k.
  logic [31:0] mem [0:1023];
  initial for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
  always @(posedge clk) imem_rdata_i <= mem[imem_addr_o[11:2]];

  int tests = 0;
  int fails = 0;
  int hold_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: new output after a non-stalled edge pops the scoreboard;
  // output after a stalled edge must equal the previous sample.
  logic        stall_at_edge = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instn = '0;
  logic [31:0] prev_pc = '0;
  logic [31:0] mon_pc;
  always @(posedge clk) stall_at_edge <= stall_i;

  always @(negedge clk) begin
    if (instn_valid_o) begin
      if (stall_at_edge && prev_valid) begin
        hold_cnt++;
        chk("hold_instn", instn_o, prev_instn);
        chk("hold_pc", instn_pc_o, prev_pc);
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got pc %h expected none", instn_pc_o);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("out_pc", instn_pc_o, mon_pc);
        chk("out_instn", instn_o, {22'd0, mon_pc[11:2]});
        chk("out_nextpc", nextpc_o, mon_pc + 32'd4);
      end
    end
    prev_valid = instn_valid_o;
    prev_instn = instn_o;
    prev_pc    = instn_pc_o;
  end

  task automatic push_run(input int lo, input int hi);
    for (int a = lo; a <= hi; a += 4) exp_q.push_back(32'(a));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instn"}, instn_o, 32'd0);
    chk({tag, "_pc"}, instn_pc_o, 32'd0);
    chk({tag, "_nextpc"}, nextpc_o, 32'd4);
    chk({tag, "_valid"}, {31'd0, instn_valid_o}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted_o}, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    chk({tag, "_range"}, {31'd0, range_err_o}, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk({tag, "_fetch_cnt"}, fetch_cnt_o, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt_o, 32'd0);
`endif
  endtask

  // One reset edge, then release and check reset values.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    stall_i = 1'b0;
    #1 chk_reset(tag);
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(instn_valid_o && instn_pc_o == pc) && n < budget);
    if (!(instn_valid_o && instn_pc_o == pc)) begin
      tests++;
      fails++;
      $display("FAIL wait_pc timeout: got pc %h expected %h", instn_pc_o, pc);
    end
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, {31'd0, halted_o}, 32'd1);
    chk({tag, "_valid"}, {31'd0, instn_valid_o}, 32'd0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset("rst");

    // Straight line: pcs 0..32, halt, END_ADDR never delivered.
    push_run(0, 32);
    reset = 1'b0;
    wait_halt("line", 40);
    chk("line_range", {31'd0, range_err_o}, 32'd0);
    // Redirect is ignored once halted.
    branch_taken_i = 1'b1;
    branch_target_i = 32'h10;
    @(negedge clk);
    branch_taken_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_branch_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_branch_valid", {31'd0, instn_valid_o}, 32'd0);

    // Stall 3 cycles while pc 8 is on the output; F2 address replayed.
    do_reset("rst_stall");
    hold_cnt = 0;
    push_run(0, 32);
    wait_pc(32'd8, 20);
    stall_i = 1'b1;
    #1 chk("stall_addr", imem_addr_o, 32'd12);
    repeat (3) @(negedge clk);
    stall_i = 1'b0;
    wait_halt("stall", 40);
    chk("stall_holds", 32'(hold_cnt), 32'd3);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("perf_fetch", fetch_cnt_o, 32'd9);
    chk("perf_stall", stall_cnt_o, 32'd3);
`endif

    // Branch to 0x14 while pc 4 shown: two bubbles, 8/12 squashed.
    do_reset("rst_br");
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    push_run(20, 32);
    wait_pc(32'd4, 20);
    branch_taken_i = 1'b1;
    branch_target_i = 32'h14;
    @(negedge clk);
    branch_taken_i = 1'b0;
    chk("br_bubble1", {31'd0, instn_valid_o}, 32'd0);
    chk("br_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    chk("br_bubble2", {31'd0, instn_valid_o}, 32'd0);
    wait_halt("br", 40);

    // Branch with stall to misaligned 0x0B: redirect to 0x08, one-cycle pulse.
    do_reset("rst_mis");
    push_run(0, 32);
    wait_pc(32'd4, 20);
    stall_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 32'h0B;
    @(negedge clk);
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_bubble", {31'd0, instn_valid_o}, 32'd0);
    @(negedge clk);
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);
    wait_halt("mis", 40);

    // Branch near the top of the address space: range error and wrap to 0.
    do_reset("rst_rng");
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    push_run(0, 32);
    wait_pc(32'd0, 20);
    chk("rng_before", {31'd0, range_err_o}, 32'd0);
    branch_taken_i = 1'b1;
    branch_target_i = 32'hFFFF_FFF8;
    @(negedge clk);
    branch_taken_i = 1'b0;
    wait_halt("rng", 60);
    chk("rng_sticky", {31'd0, range_err_o}, 32'd1);

    // Reset after a halt clears halted_o; then reset mid-run while stalled.
    do_reset("rst_after_halt");
    push_run(0, 16);
    wait_pc(32'h10, 20);
    stall_i = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_i = 1'b0;
    chk("mid_q_empty", 32'(exp_q.size()), 32'd0);
    #1 chk_reset("rst_mid");
    push_run(0, 32);
    wait_halt("restart", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
